sprite_rom_arbiter: RTL and testbench

Round-robin arbiter sharing one palette-indexed sprite image ROM (8-bit index per pixel, registered-output block RAM) among several sprite pixel pipelines. Each requester presents a ROM address. The arbiter grants one requester per cycle and drives the shared ROM address port. It tracks every in-flight read through a tag pipeline matched to the ROM latency, then returns the ROM data to the requester that issued it. It sits between the sprite renderers and the shared image ROM, ahead of the palette lookup.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_rom_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sprite_rom_arbiter.sv | 114 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
//   SPRITE_W/SPRITE_H/FRAME_WORDS : geometry of one sprite image frame
//   DEF_*                         : default arbiter parameters
//   rom_tag_t                     : one in-flight read tag {valid, requester id}
package sprite_pkg;

  localparam int unsigned SPRITE_W    = 256;
  localparam int unsigned SPRITE_H    = 256;
  localparam int unsigned FRAME_WORDS = 65536;

  localparam int unsigned DEF_ADDR_W      = 17;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ROM_LATENCY = 2;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } rom_tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite renderers/ROM and the arbiter.
//   req, req_addr       : per-requester read request and flattened addresses
//   gnt                 : combinational one-hot grant
//   rom_addr, rom_en    : shared ROM address port
//   rom_data            : shared ROM read data
//   rsp_valid, rsp_data : one-hot response owner and returned palette index
// master = requesters + ROM side, slave = arbiter.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic                    rom_en;
  logic [DATA_W-1:0]       rom_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rom_addr, rom_en, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rom_addr, rom_en, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N_REQ-way round-robin picker.
//   req    : request vector
//   ptr    : highest-priority requester this cycle
//   enable : gates all grants
//   gnt    : one-hot or zero grant
//   gnt_id : index of the granted requester (valid when any)
//   any    : a grant is issued
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_id,
  output logic             any
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]   offset;
  logic [PTR_W:0]     id_sum;

  // Rotate so bit 0 is the requester at ptr, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N_REQ-1:0];
    offset  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) offset = PTR_W'(j);
    end
    any    = enable && (|req_rot);
    id_sum = {1'b0, ptr} + {1'b0, offset};
    if (id_sum >= N_EXT) id_sum = id_sum - N_EXT;
    gnt_id = id_sum[PTR_W-1:0];
    gnt    = '0;
    if (any) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite image ROM among
// several sprite pixel pipelines; returns each read to the requester that issued it.
//   pixel_clk, rst_n : clock, asynchronous active-low reset
//   enable           : low blocks new grants, in-flight reads still complete
//   flush            : discards every in-flight read
//   bus (slave)      : requests/grants, ROM port and responses
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ROM_LATENCY = DEF_ROM_LATENCY
) (
  input logic                 pixel_clk,
  input logic                 rst_n,
  input logic                 enable,
  input logic                 flush,
  sprite_rom_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  // Stage 0 rides with rom_addr; one more stage covers the ROM sampling edge,
  // then ROM_LATENCY stages until rom_data is valid.
  localparam int unsigned TAG_DEPTH = ROM_LATENCY + 2;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  gnt_c;
  logic [PTR_W-1:0]  gnt_id;
  logic              any_gnt;
  logic              arb_en;
  logic [ADDR_W-1:0] sel_addr;
  rom_tag_t          tag_in;
  rom_tag_t          tag_last;

  rom_tag_t [TAG_DEPTH-1:0] tag_q;
  logic [ADDR_W-1:0]        rom_addr_q;
  logic                     rom_en_q;
  logic [N_REQ-1:0]         rsp_valid_q;
  logic [DATA_W-1:0]        rsp_data_q;

  // No grants during reset or flush.
  assign arb_en = rst_n && enable && !flush;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (ptr),
    .enable (arb_en),
    .gnt    (gnt_c),
    .gnt_id (gnt_id),
    .any    (any_gnt)
  );

  // Address of the granted requester and the tag entering the pipeline.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
    tag_in.valid = any_gnt;
    tag_in.id    = 3'(gnt_id);
    tag_last     = tag_q[TAG_DEPTH-1];
  end

  // Pointer and shared ROM address port.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      rom_en_q <= any_gnt;
      if (any_gnt) begin
        rom_addr_q <= sel_addr;
        ptr        <= (gnt_id == LAST_ID) ? '0 : gnt_id + PTR_W'(1);
      end
    end
  end

  // Tag pipeline tracking in-flight reads.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (flush) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[TAG_DEPTH-2:0], tag_in};
    end
  end

  // Response capture; flush overrides a read reaching the last stage.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (!flush && tag_last.valid) begin
      rsp_valid_q <= N_REQ'(1) << tag_last.id;
      rsp_data_q  <= bus.rom_data;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_en    = rom_en_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a ROM model and a response scoreboard.
module tb_sprite_rom_arbiter;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [7:0] data;
  } exp_t;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b1;
  logic        flush     = 1'b0;
  logic [3:0]  req       = 4'b1111;
  logic [16:0] addr [4];
  logic        advance   = 1'b1;

  logic [16:0] rom_a_s = '0;
  logic [7:0]  rom_d0  = '0;
  logic [7:0]  rom_d1  = '0;

  int          edge_n = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  ptr_m = '0;
  logic [16:0] rom_addr_m = '0;
  exp_t        sb [$];

  sprite_rom_arbiter_if bus ();

  sprite_rom_arbiter dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) edge_n <= edge_n + 1;

  function automatic logic [7:0] rom_fn(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'b0} ^ 8'h78;
  endfunction

  // ROM: samples rom_addr one edge after it is driven, data out two edges later.
  always @(posedge pixel_clk) begin
    rom_a_s <= bus.rom_addr;
    rom_d0  <= rom_fn(rom_a_s);
    rom_d1  <= rom_d0;
  end

  assign bus.rom_data = rom_d1;
  assign bus.req      = req;
  assign bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: entered at a negedge with inputs applied, returns at the next negedge.
  task automatic step();
    logic       hit;
    logic [1:0] gid;
    logic [1:0] idx;
    #1;
    hit = 1'b0;
    gid = '0;
    if (rst_n && enable && !flush) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_m + 2'(k);
        if (!hit && req[idx]) begin
          hit = 1'b1;
          gid = idx;
        end
      end
    end
    check("gnt", 32'(bus.gnt), hit ? 32'(4'b0001 << gid) : 32'd0);
    if (flush && rst_n) sb.delete();
    if (hit) begin
      sb.push_back('{due: edge_n + 5, oh: 4'b0001 << gid, data: rom_fn(addr[gid])});
      ptr_m      = gid + 2'd1;
      rom_addr_m = addr[gid];
    end
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    check("rom_en", 32'(bus.rom_en), 32'(hit));
    check("rom_addr", 32'(bus.rom_addr), 32'(rom_addr_m));
    if (hit && advance) addr[gid] = addr[gid] + 17'h00a37;
  endtask

  task automatic idle(input int n);
    req = 4'b0000;
    repeat (n) step();
  endtask

  // Asserts reset mid-cycle and checks every output clears at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_rom_en", 32'(bus.rom_en), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    sb.delete();
    ptr_m      = '0;
    rom_addr_m = '0;
    @(negedge pixel_clk);
  endtask

  initial begin
    addr[0] = 17'h00123;
    addr[1] = 17'h01456;
    addr[2] = 17'h10789;
    addr[3] = 17'h0fabc;

    // Response scoreboard: every negedge either the head entry is due or nothing fires.
    fork
      forever begin
        @(negedge pixel_clk);
        if (sb.size() != 0 && sb[0].due == edge_n) begin
          check("rsp_valid", 32'(bus.rsp_valid), 32'(sb[0].oh));
          check("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
          sb.delete(0);
        end else begin
          check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        end
      end
    join_none

    // Reset from time zero with all requests high.
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    check("init_gnt", 32'(bus.gnt), 32'd0);
    check("init_rom_en", 32'(bus.rom_en), 32'd0);
    check("init_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("init_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("init_rsp_data", 32'(bus.rsp_data), 32'd0);

    // Single request to address 0x00123 (ROM returns 0x5A).
    rst_n   = 1'b1;
    advance = 1'b0;
    req     = 4'b0001;
    step();
    idle(6);

    // All four continuously from reset.
    do_reset();
    rst_n   = 1'b1;
    advance = 1'b1;
    req     = 4'b1111;
    repeat (8) step();

    // Pointer wrap: drive ptr to 3, then only requesters 1 and 3.
    req = 4'b0100;
    step();
    req = 4'b1010;
    step();
    req = 4'b0010;
    step();
    req = 4'b0011;
    step();
    idle(6);

    // Flush with three reads in flight.
    req = 4'b1111;
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(6);
    req = 4'b0001;
    step();
    idle(6);

    // Reset with the pipeline full, then a two-requester release.
    req = 4'b1111;
    repeat (4) step();
    do_reset();
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    idle(6);

    // Enable low while everyone requests; in-flight reads still return.
    req = 4'b1111;
    repeat (2) step();
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (3) step();

    // Drain with a bounded budget.
    req = 4'b0000;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
